// File: rtl/hx711_tare_avg.sv
// hx711_tare_avg
//   Averages HX711 load-cell conversions over windows of N = 2^LOG2_N
//   samples, subtracts a tare offset and saturates the result to 24 bits.
//   A tare request discards the partial window and uses the next full
//   window's average as the new tare offset.
//
// Ports
//   clk          single clock
//   rst          synchronous, active-high reset
//   sample_in    24-bit two's-complement conversion result
//   sample_valid one-cycle strobe qualifying sample_in
//   tare_req     one-cycle tare request strobe
//   weight_out   averaged, tare-corrected, saturated signed result
//   weight_valid one-cycle strobe qualifying weight_out
//   sat          weight_out was clamped (updates with weight_out)
//   tare_busy    high while a tare window is being collected
//   no_data      high when no sample arrived for TIMEOUT cycles
module hx711_tare_avg #(
  parameter int LOG2_N  = 2,
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [23:0] sample_in,
  input  logic               sample_valid,
  input  logic               tare_req,
  output logic signed [23:0] weight_out,
  output logic               weight_valid,
  output logic               sat,
  output logic               tare_busy,
  output logic               no_data
);

  localparam int DATA_W = 24;
  localparam int ACC_W  = DATA_W + LOG2_N;
  localparam int DIFF_W = DATA_W + 1;

  localparam logic signed [DIFF_W-1:0] POS_LIM = DIFF_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [DIFF_W-1:0] NEG_LIM = DIFF_W'(-(2 ** (DATA_W - 1)));
  localparam logic [TO_W-1:0]          TO_LIM  = TO_W'(TIMEOUT);

  typedef enum logic {
    S_ACC,
    S_TARE
  } state_t;

  state_t                    state;
  logic signed [ACC_W-1:0]   acc;
  logic [LOG2_N-1:0]         cnt;
  logic signed [DATA_W-1:0]  tare_offset;
  logic signed [DATA_W-1:0]  avg_p0;
  logic                      vld_p0;
  logic [TO_W-1:0]           to_cnt;

  logic signed [ACC_W-1:0]   sample_ext;
  logic signed [ACC_W-1:0]   sum;
  logic signed [DATA_W-1:0]  avg;
  logic                      last;
  logic signed [DIFF_W-1:0]  diff_p0;
  logic [TO_W-1:0]           to_next;

  // Clamp a 25-bit difference into the 24-bit signed output range.
  function automatic logic signed [DATA_W-1:0] sat24(input logic signed [DIFF_W-1:0] d);
    logic signed [DATA_W-1:0] r;
    if (d > POS_LIM) begin
      r = {1'b0, {(DATA_W - 1){1'b1}}};
    end else if (d < NEG_LIM) begin
      r = {1'b1, {(DATA_W - 1){1'b0}}};
    end else begin
      r = d[DATA_W-1:0];
    end
    return r;
  endfunction

  function automatic logic is_clamped(input logic signed [DIFF_W-1:0] d);
    return (d > POS_LIM) || (d < NEG_LIM);
  endfunction

  always_comb begin
    sample_ext = {{LOG2_N{sample_in[DATA_W-1]}}, sample_in};
    sum        = acc + sample_ext;
    // Arithmetic shift floors toward minus infinity; the quotient always
    // fits back into DATA_W bits.
    avg        = DATA_W'(sum >>> LOG2_N);
    last       = (cnt == '1);
    diff_p0    = {avg_p0[DATA_W-1], avg_p0} - {tare_offset[DATA_W-1], tare_offset};
    if (sample_valid) begin
      to_next = '0;
    end else if (to_cnt == TO_LIM) begin
      to_next = to_cnt;
    end else begin
      to_next = to_cnt + 1'b1;
    end
  end

  // Stage p0: window accumulation, tare FSM and average capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_ACC;
      acc         <= '0;
      cnt         <= '0;
      tare_offset <= '0;
      tare_busy   <= 1'b0;
      vld_p0      <= 1'b0;
    end else begin
      vld_p0 <= 1'b0;
      unique case (state)
        S_ACC: begin
          // A tare request wins over a coincident sample, which is dropped.
          if (tare_req) begin
            acc       <= '0;
            cnt       <= '0;
            state     <= S_TARE;
            tare_busy <= 1'b1;
          end else if (sample_valid) begin
            if (last) begin
              acc    <= '0;
              cnt    <= '0;
              avg_p0 <= avg;
              vld_p0 <= 1'b1;
            end else begin
              acc <= sum;
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_TARE: begin
          // Further tare requests are ignored until this window completes.
          if (sample_valid) begin
            if (last) begin
              acc         <= '0;
              cnt         <= '0;
              tare_offset <= avg;
              state       <= S_ACC;
              tare_busy   <= 1'b0;
            end else begin
              acc <= sum;
              cnt <= cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Stage p1: tare subtraction and saturation
  always_ff @(posedge clk) begin
    if (rst) begin
      weight_out   <= '0;
      weight_valid <= 1'b0;
      sat          <= 1'b0;
    end else begin
      weight_valid <= vld_p0;
      if (vld_p0) begin
        weight_out <= sat24(diff_p0);
        sat        <= is_clamped(diff_p0);
      end
    end
  end

  // no_data follows the next counter value so it drops the cycle right
  // after a sample and rises the cycle the counter reaches TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt  <= '0;
      no_data <= 1'b0;
    end else begin
      to_cnt  <= to_next;
      no_data <= (to_next == TO_LIM);
    end
  end

endmodule
